axi_sony_imx_stream_packer: RTL and testbench

//  Consumes one camera's synchronized lane data plus VS/HS from axi_sony_imx_control and emits
//  AXI-Stream video: one beat per active HS cycle, tuser on frame start, tlast on line end.
//  A small FIFO absorbs downstream backpressure. Drops and line/frame counts are reported to the register block.

---
 rtl/sony_imx_pkg.sv | 19 +
 rtl/axis_sync_fifo.sv | 63 ++++++
 rtl/axi_sony_imx_stream_packer.sv | 193 +++++++++++++++++++
 tb/tb_axi_sony_imx_stream_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sony_imx_pkg.sv
// Shared types for the Sony IMX camera capture path: packer FSM states and lane geometry.
package sony_imx_pkg;

  localparam int LANE_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_HS = 3'd2,
    SKIP    = 3'd3,
    ACTIVE  = 3'd4
  } state_t;

  // Status counters stick at all-ones rather than wrapping to a misleading small value.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on pop_data whenever not empty.
module axis_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rd_en   = pop & ~empty;
  assign wr_en   = push & (~full | rd_en);
  assign push_ok = wr_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Gating keeps the stream outputs at zero while nothing is queued (including straight after reset).
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axi_sony_imx_stream_packer.sv
// Turns one camera's synchronized lane words plus VS/HS into an AXI-Stream video stream
// with tuser on start of frame and tlast on end of line, buffered by a small FIFO.
module axi_sony_imx_stream_packer
  import sony_imx_pkg::*;
#(
  parameter int LANE_WIDTH   = 8,
  parameter int HEADER_WORDS = 10,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              i_axi_clk,
  input  logic                              i_axi_rst_n,
  input  logic                              i_enable,
  input  logic                              i_clear_overflow,
  input  logic [LANE_BYTE_W*LANE_WIDTH-1:0] i_sync_data,
  input  logic                              i_imx_vs,
  input  logic                              i_imx_hs,
  output logic                              o_axis_tvalid,
  input  logic                              i_axis_tready,
  output logic [LANE_BYTE_W*LANE_WIDTH-1:0] o_axis_tdata,
  output logic                              o_axis_tuser,
  output logic                              o_axis_tlast,
  output logic                              o_overflow,
  output logic [15:0]                       o_line_count,
  output logic [31:0]                       o_frame_count
);

  localparam int DATA_W = LANE_BYTE_W * LANE_WIDTH;
  localparam int FIFO_W = DATA_W + 2;
  localparam int SKIP_W = $clog2(HEADER_WORDS + 1);

  state_t              state;
  state_t              next_state;
  logic                vs_d;
  logic                hs_d;
  logic                vs_rise;
  logic                hs_rise;
  logic                hs_fall;
  logic                line_end;
  logic                frame_start;
  logic                skip_load;
  logic                skip_inc;
  logic                capture;
  logic [SKIP_W-1:0]   skip_cnt;
  logic                stage_valid;
  logic [DATA_W-1:0]   stage_data;
  logic                sof;
  logic                push;
  logic                push_ok;
  logic                push_last;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_W-1:0]   push_word;
  logic [FIFO_W-1:0]   head_word;

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      vs_d <= 1'b0;
      hs_d <= 1'b0;
    end else begin
      vs_d <= i_imx_vs;
      hs_d <= i_imx_hs;
    end
  end

  assign vs_rise = i_imx_vs & ~vs_d;
  assign hs_rise = i_imx_hs & ~hs_d;
  assign hs_fall = ~i_imx_hs & hs_d;
  // VS dropping while HS is still high closes the line exactly like an HS fall.
  assign line_end = hs_fall | ~i_imx_vs;

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_enable) next_state = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) next_state = WAIT_HS;
      end
      WAIT_HS: begin
        // Enable is only looked at here, once the frame has fully ended.
        if (!i_imx_vs)    next_state = i_enable ? WAIT_VS : IDLE;
        else if (hs_rise) next_state = (HEADER_WORDS <= 1) ? ACTIVE : SKIP;
      end
      SKIP: begin
        if (line_end)                                   next_state = WAIT_HS;
        else if (skip_cnt >= SKIP_W'(HEADER_WORDS - 1)) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (line_end) next_state = WAIT_HS;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state == WAIT_VS) & vs_rise;
    skip_load   = (state == WAIT_HS) & i_imx_vs & hs_rise;
    skip_inc    = (state == SKIP) & ~line_end;
    capture     = (state == ACTIVE) & ~line_end;
  end

  // The HS rise cycle is header word 1, so the counter starts at 1 there.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      skip_cnt <= '0;
    end else if (skip_load) begin
      skip_cnt <= SKIP_W'(1);
    end else if (skip_inc) begin
      skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end

  // One-word lookahead: a word is only known to be the last once the next cycle shows no capture.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_data <= i_sync_data;
      end
    end
  end

  assign push      = stage_valid;
  assign push_last = ~capture;
  assign push_word = {sof, push_last, stage_data};
  assign pop       = o_axis_tvalid & i_axis_tready;
  assign drop      = push & ~push_ok;

  axis_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_axi_clk),
    .rst_n     (i_axi_rst_n),
    .push      (push),
    .push_data (push_word),
    .push_ok   (push_ok),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_axis_tvalid = ~fifo_empty;
  assign {o_axis_tuser, o_axis_tlast, o_axis_tdata} = head_word;

  // sof survives a dropped beat so tuser still reaches the first beat that makes it downstream.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      sof           <= 1'b0;
      o_overflow    <= 1'b0;
      o_line_count  <= '0;
      o_frame_count <= '0;
    end else begin
      if (frame_start) begin
        sof <= 1'b1;
      end else if (push_ok) begin
        sof <= 1'b0;
      end

      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        o_overflow <= 1'b0;
      end

      if (frame_start) begin
        o_line_count <= '0;
      end else if (push && push_last) begin
        o_line_count <= sat_inc16(o_line_count);
      end

      if (frame_start) begin
        o_frame_count <= o_frame_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_sony_imx_stream_packer.sv
// Scoreboard bench for the IMX stream packer: stimulus queues expected beats, a negedge monitor checks them.
module tb_axi_sony_imx_stream_packer;

  localparam int HEADER_WORDS = 10;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear_overflow;
  logic [63:0] sync_data;
  logic        vs;
  logic        hs;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        overflow;
  logic [15:0] line_count;
  logic [31:0] frame_count;

  beat_t exp_q[$];
  logic  sof_exp;
  int    test_count;
  int    fail_count;

  axi_sony_imx_stream_packer #(
    .LANE_WIDTH   (8),
    .HEADER_WORDS (HEADER_WORDS),
    .FIFO_DEPTH   (16)
  ) dut (
    .i_axi_clk        (clk),
    .i_axi_rst_n      (rst_n),
    .i_enable         (enable),
    .i_clear_overflow (clear_overflow),
    .i_sync_data      (sync_data),
    .i_imx_vs         (vs),
    .i_imx_hs         (hs),
    .o_axis_tvalid    (tvalid),
    .i_axis_tready    (tready),
    .o_axis_tdata     (tdata),
    .o_axis_tuser     (tuser),
    .o_axis_tlast     (tlast),
    .o_overflow       (overflow),
    .o_line_count     (line_count),
    .o_frame_count    (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Line 99 carries the hand-picked lane0 pattern; other lines use a simple per-lane ramp.
  function automatic logic [63:0] word_val(input int line_id, input int w);
    logic [63:0] v;
    v = '0;
    if (line_id == 99) begin
      case (w)
        11:      v[7:0] = 8'h7F;
        12:      v[7:0] = 8'h80;
        13:      v[7:0] = 8'h00;
        14:      v[7:0] = 8'h40;
        default: v[7:0] = 8'hA5;
      endcase
    end else begin
      for (int k = 0; k < 8; k++) begin
        v[8*k +: 8] = 8'((line_id * 16 + w + k * 3) & 255);
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        test_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_beat: actual data %0h user %0b last %0b, required no beat", tdata, tuser, tlast);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_output("tdata", tdata, e.data);
        check_output("tuser", 64'(tuser), 64'(e.user));
        check_output("tlast", 64'(tlast), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input bit expect_sof);
    vs = 1'b1;
    if (expect_sof) sof_exp = 1'b1;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    vs = 1'b0;
    repeat (6) tick();
  endtask

  // Drives one HS-high line of nwords words; the first keep_max payload beats are expected downstream.
  task automatic apply_stimulus(input int nwords, input int line_id, input int keep_max);
    int kept;
    kept = 0;
    for (int w = 1; w <= nwords; w++) begin
      sync_data = word_val(line_id, w);
      hs = 1'b1;
      if (w > HEADER_WORDS && kept < keep_max) begin
        exp_q.push_back('{word_val(line_id, w), sof_exp, (w == nwords)});
        sof_exp = 1'b0;
        kept++;
      end
      tick();
    end
    hs = 1'b0;
    sync_data = '0;
    repeat (12) tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    check_output("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    test_count     = 0;
    fail_count     = 0;
    sof_exp        = 1'b0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    clear_overflow = 1'b0;
    sync_data      = '0;
    vs             = 1'b0;
    hs             = 1'b0;
    tready         = 1'b1;

    repeat (3) tick();
    check_output("rst_tvalid", 64'(tvalid), 64'd0);
    check_output("rst_tdata", tdata, 64'd0);
    check_output("rst_tuser", 64'(tuser), 64'd0);
    check_output("rst_tlast", 64'(tlast), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_line_count", 64'(line_count), 64'd0);
    check_output("rst_frame_count", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] full frame of 10 lines");
    enable = 1'b1;
    repeat (3) tick();
    begin_frame(1'b1);
    for (int l = 0; l < 10; l++) apply_stimulus(100, l, 1000);
    wait_drain();
    check_output("t1_line_count", 64'(line_count), 64'd10);
    check_output("t1_frame_count", 64'(frame_count), 64'd1);
    end_frame();

    $display("[TB] lane0 data pattern");
    begin_frame(1'b1);
    apply_stimulus(14, 99, 1000);
    wait_drain();
    check_output("t2_line_count", 64'(line_count), 64'd1);
    check_output("t2_frame_count", 64'(frame_count), 64'd2);
    end_frame();

    $display("[TB] backpressure overflow");
    tready = 1'b0;
    begin_frame(1'b1);
    apply_stimulus(100, 7, 16);
    check_output("t3_overflow_set", 64'(overflow), 64'd1);
    check_output("t3_tvalid_held", 64'(tvalid), 64'd1);
    check_output("t3_line_count", 64'(line_count), 64'd1);
    tready = 1'b1;
    wait_drain();
    check_output("t3_overflow_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_output("t3_overflow_cleared", 64'(overflow), 64'd0);
    end_frame();

    $display("[TB] short lines");
    begin_frame(1'b1);
    apply_stimulus(8, 20, 1000);
    check_output("t4_short_line_count", 64'(line_count), 64'd0);
    apply_stimulus(11, 21, 1000);
    wait_drain();
    check_output("t4_min_line_count", 64'(line_count), 64'd1);
    check_output("t4_frame_count", 64'(frame_count), 64'd4);
    end_frame();

    $display("[TB] enable dropped mid-frame");
    begin_frame(1'b1);
    apply_stimulus(30, 1, 1000);
    enable = 1'b0;
    apply_stimulus(30, 2, 1000);
    apply_stimulus(30, 3, 1000);
    end_frame();
    wait_drain();
    check_output("t5_line_count", 64'(line_count), 64'd3);
    check_output("t5_frame_count", 64'(frame_count), 64'd5);
    begin_frame(1'b0);
    apply_stimulus(30, 4, 0);
    end_frame();
    check_output("t5_frozen_frame_count", 64'(frame_count), 64'd5);
    check_output("t5_frozen_line_count", 64'(line_count), 64'd3);

    $display("[TB] reset mid-line");
    enable = 1'b1;
    tready = 1'b0;
    repeat (3) tick();
    begin_frame(1'b0);
    for (int w = 1; w <= 20; w++) begin
      sync_data = word_val(30, w);
      hs = 1'b1;
      tick();
    end
    check_output("t6_tvalid_before_reset", 64'(tvalid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_tvalid", 64'(tvalid), 64'd0);
    check_output("t6_rst_tdata", tdata, 64'd0);
    check_output("t6_rst_tuser", 64'(tuser), 64'd0);
    check_output("t6_rst_frame_count", 64'(frame_count), 64'd0);
    check_output("t6_rst_line_count", 64'(line_count), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int w = 21; w <= 30; w++) begin
      sync_data = word_val(30, w);
      tick();
    end
    hs = 1'b0;
    repeat (5) tick();
    end_frame();
    tready = 1'b1;
    begin_frame(1'b1);
    apply_stimulus(30, 5, 1000);
    wait_drain();
    check_output("t6_frame_count", 64'(frame_count), 64'd1);
    check_output("t6_line_count", 64'(line_count), 64'd1);
    end_frame();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
